stopwatch_timer: RTL and testbench

- Consumes the slow square-wave tick outputs of the system clock divider, the 1 ms tick and the debounce tick, inside the single clkin domain.
- Converts their edges into one-cycle strobes.
- Debounces two push-buttons.
- Runs a BCD MM:SS.cc stopwatch (start/stop/clear FSM) whose outputs drive the seven-segment display logic.

---
 rtl/stopwatch_pkg.sv | 61 ++++++
 rtl/button_debounce.sv | 52 +++++
 rtl/stopwatch_timer.sv | 174 +++++++++++++++++
 tb/tb_stopwatch_timer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch_timer slice.
//   state_t    : stopwatch FSM states (IDLE/RUN/PAUSE)
//   bcd_t      : one BCD digit
//   sw_time_t  : MM:SS.cc display value as six packed BCD digits
//   time_inc() : one-centisecond BCD increment with full carry cascade
//                (59:59.99 wraps to 00:00.00)
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t min_tens;
      bcd_t min_ones;
      bcd_t sec_tens;
      bcd_t sec_ones;
      bcd_t centi_tens;
      bcd_t centi_ones;
   } sw_time_t;

   localparam bcd_t     DIGIT_MAX           = 4'd9;
   localparam bcd_t     SEC_MAX_TENS        = 4'd5;
   localparam int       DEB_SAMPLES_DEFAULT = 4;
   localparam sw_time_t TIME_MAX            = sw_time_t'(24'h595999);

   // Every digit carry resolves in one call, so the whole cascade lands
   // in the same clock cycle as the centisecond tick.
   function automatic sw_time_t time_inc(input sw_time_t t);
      sw_time_t r;
      r = t;
      if (t.centi_ones != DIGIT_MAX) r.centi_ones = t.centi_ones + 4'd1;
      else begin
         r.centi_ones = '0;
         if (t.centi_tens != DIGIT_MAX) r.centi_tens = t.centi_tens + 4'd1;
         else begin
            r.centi_tens = '0;
            if (t.sec_ones != DIGIT_MAX) r.sec_ones = t.sec_ones + 4'd1;
            else begin
               r.sec_ones = '0;
               if (t.sec_tens != SEC_MAX_TENS) r.sec_tens = t.sec_tens + 4'd1;
               else begin
                  r.sec_tens = '0;
                  if (t.min_ones != DIGIT_MAX) r.min_ones = t.min_ones + 4'd1;
                  else begin
                     r.min_ones = '0;
                     if (t.min_tens != SEC_MAX_TENS) r.min_tens = t.min_tens + 4'd1;
                     else                            r.min_tens = '0;
                  end
               end
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, consecutive-sample
// debounce counter and a one-cycle press pulse on a stable 0->1 change.
// Ports:
//   clkin     : system clock
//   rst_n     : synchronous active-low reset
//   raw       : asynchronous button level, 1 = pressed
//   sample_en : one-cycle debounce sample strobe
//   press     : one-cycle pulse when the stable level rises
module button_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEB_SAMPLES = DEB_SAMPLES_DEFAULT
) (
   input  logic clkin,
   input  logic rst_n,
   input  logic raw,
   input  logic sample_en,
   output logic press
);

   logic [1:0] sync_q;
   logic       stable_q;
   logic [3:0] count_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         count_q  <= '0;
         press    <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw};
         press  <= 1'b0;
         if (sample_en) begin
            if (sync_q[1] != stable_q) begin
               if (count_q == 4'(DEB_SAMPLES - 1)) begin
                  stable_q <= sync_q[1];
                  count_q  <= '0;
                  press    <= sync_q[1];  // release produces no pulse
               end else begin
                  count_q <= count_q + 4'd1;
               end
            end else begin
               count_q <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/stopwatch_timer.sv
// BCD MM:SS.cc stopwatch with start/stop/clear FSM.
// Optional lap-hold feature enabled by defining STOPWATCH_LAP_EN.
// Ports:
//   clkin          : system clock
//   rst_n          : synchronous active-low reset
//   tick_mili      : 1 ms square wave, one event per rising edge
//   tick_debounce  : debounce sample square wave, one event per rising edge
//   btn_startstop  : raw start/stop button
//   btn_clear      : raw clear button
//   centi_bcd      : centiseconds, two BCD digits
//   sec_bcd        : seconds, two BCD digits
//   min_bcd        : minutes, two BCD digits
//   running        : high while in RUN
//   overflow       : sticky, set on rollover past 59:59.99
//   btn_lap        : (STOPWATCH_LAP_EN) raw lap button
//   lap_active     : (STOPWATCH_LAP_EN) display frozen on lap snapshot
module stopwatch_timer
   import stopwatch_pkg::*;
#(
   parameter int DEB_SAMPLES  = DEB_SAMPLES_DEFAULT,
   parameter int MS_PER_CENTI = 10
) (
   input  logic       clkin,
   input  logic       rst_n,
   input  logic       tick_mili,
   input  logic       tick_debounce,
   input  logic       btn_startstop,
   input  logic       btn_clear,
   output logic [7:0] centi_bcd,
   output logic [7:0] sec_bcd,
   output logic [7:0] min_bcd,
   output logic       running,
   output logic       overflow
`ifdef STOPWATCH_LAP_EN
   ,
   input  logic       btn_lap,
   output logic       lap_active
`endif
);

   localparam int PW = (MS_PER_CENTI > 1) ? $clog2(MS_PER_CENTI) : 1;

   // Two synchroniser flops plus one history flop per tick input.
   logic [2:0] ms_sh;
   logic [2:0] deb_sh;
   logic       ms_stb;
   logic       deb_stb;

   logic       start_press;
   logic       clear_press;

   state_t     state_q, state_d;
   sw_time_t   time_q, time_d;
   logic [PW-1:0] presc_q, presc_d;
   logic       ovf_d;
   logic       centi_tick;
   logic       wrap;
   logic       do_clear;
   sw_time_t   shown;

   assign ms_stb  = ms_sh[1]  & ~ms_sh[2];
   assign deb_stb = deb_sh[1] & ~deb_sh[2];

   button_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_start (
      .clkin     (clkin),
      .rst_n     (rst_n),
      .raw       (btn_startstop),
      .sample_en (deb_stb),
      .press     (start_press)
   );

   button_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_clear (
      .clkin     (clkin),
      .rst_n     (rst_n),
      .raw       (btn_clear),
      .sample_en (deb_stb),
      .press     (clear_press)
   );

   assign centi_tick = (state_q == RUN) && ms_stb && (presc_q == PW'(MS_PER_CENTI - 1));
   assign wrap       = centi_tick && (time_q == TIME_MAX);
   assign do_clear   = clear_press && (state_q != RUN);

   // NOTE: every signal written here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      presc_d = presc_q;
      ovf_d   = overflow;

      unique case (state_q)
         IDLE:    if (!clear_press && start_press) state_d = RUN;
         RUN:     if (wrap || start_press)         state_d = PAUSE;
         PAUSE: begin
            if (clear_press)      state_d = IDLE;
            else if (start_press) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase

      if (do_clear) begin
         time_d  = '0;
         presc_d = '0;
         ovf_d   = 1'b0;
      end else if ((state_q == RUN) && ms_stb) begin
         // The strobe is counted even when a start press pauses this cycle.
         if (centi_tick) begin
            presc_d = '0;
            time_d  = time_inc(time_q);
            if (wrap) ovf_d = 1'b1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         ms_sh    <= '0;
         deb_sh   <= '0;
         state_q  <= IDLE;
         time_q   <= '0;
         presc_q  <= '0;
         overflow <= 1'b0;
      end else begin
         ms_sh    <= {ms_sh[1:0], tick_mili};
         deb_sh   <= {deb_sh[1:0], tick_debounce};
         state_q  <= state_d;
         time_q   <= time_d;
         presc_q  <= presc_d;
         overflow <= ovf_d;
      end
   end

   assign running = (state_q == RUN);

`ifdef STOPWATCH_LAP_EN
   logic     lap_press;
   logic     lap_q;
   sw_time_t snap_q;

   button_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_lap (
      .clkin     (clkin),
      .rst_n     (rst_n),
      .raw       (btn_lap),
      .sample_en (deb_stb),
      .press     (lap_press)
   );

   // Any exit from RUN (pause, rollover, clear) drops the lap hold.
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         lap_q  <= 1'b0;
         snap_q <= '0;
      end else if (state_d != RUN) begin
         lap_q <= 1'b0;
      end else if ((state_q == RUN) && lap_press) begin
         lap_q  <= ~lap_q;
         snap_q <= time_q;
      end
   end

   assign lap_active = lap_q;
   assign shown      = lap_q ? snap_q : time_q;
`else
   assign shown = time_q;
`endif

   assign centi_bcd = {shown.centi_tens, shown.centi_ones};
   assign sec_bcd   = {shown.sec_tens,   shown.sec_ones};
   assign min_bcd   = {shown.min_tens,   shown.min_ones};

endmodule

// File: tb/tb_stopwatch_timer.sv
// Self-checking bench for stopwatch_timer (DEB_SAMPLES=4, MS_PER_CENTI=10).
// Table of directed vectors for the start/pause/clear behaviour, plus
// hand-written sequences for reset hold, rollover, mid-count reset and,
// when STOPWATCH_LAP_EN is defined, lap hold.
module tb_stopwatch_timer;

   logic       clkin = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_mili = 1'b0;
   logic       tick_debounce = 1'b0;
   logic       btn_startstop = 1'b0;
   logic       btn_clear = 1'b0;
   logic [7:0] centi_bcd, sec_bcd, min_bcd;
   logic       running, overflow;
`ifdef STOPWATCH_LAP_EN
   logic       btn_lap = 1'b0;
   logic       lap_active;
`endif

   int total = 0;
   int bad   = 0;

   stopwatch_timer #(.DEB_SAMPLES(4), .MS_PER_CENTI(10)) dut (
      .clkin         (clkin),
      .rst_n         (rst_n),
      .tick_mili     (tick_mili),
      .tick_debounce (tick_debounce),
      .btn_startstop (btn_startstop),
      .btn_clear     (btn_clear),
      .centi_bcd     (centi_bcd),
      .sec_bcd       (sec_bcd),
      .min_bcd       (min_bcd),
      .running       (running),
      .overflow      (overflow)
`ifdef STOPWATCH_LAP_EN
      ,
      .btn_lap       (btn_lap),
      .lap_active    (lap_active)
`endif
   );

   always #5 clkin = ~clkin;

   typedef struct {
      bit         start;
      bit         clr;
      int         ticks;
      int         ms;
      bit         run;
      logic [7:0] mn;
      logic [7:0] sc;
      logic [7:0] ce;
      bit         ovf;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag, input bit run, input logic [7:0] mn,
                              input logic [7:0] sc, input logic [7:0] ce, input bit ovf);
      check({tag, "_running"},  32'(running),   32'(run));
      check({tag, "_min"},      32'(min_bcd),   32'(mn));
      check({tag, "_sec"},      32'(sec_bcd),   32'(sc));
      check({tag, "_centi"},    32'(centi_bcd), 32'(ce));
      check({tag, "_overflow"}, 32'(overflow),  32'(ovf));
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clkin);
   endtask

   task automatic ms_edges(input int n);
      repeat (n) begin
         tick_mili = 1'b1;
         wait_cycles(4);
         tick_mili = 1'b0;
         wait_cycles(4);
      end
   endtask

   task automatic deb_ticks(input int n);
      repeat (n) begin
         tick_debounce = 1'b1;
         wait_cycles(4);
         tick_debounce = 1'b0;
         wait_cycles(4);
      end
   endtask

   // Hold the chosen buttons for n debounce samples, then release and let
   // the debouncers settle back to the released level.
   task automatic press(input bit s, input bit c, input bit l, input int n);
      btn_startstop = s;
      btn_clear     = c;
`ifdef STOPWATCH_LAP_EN
      btn_lap       = l;
`endif
      wait_cycles(4);
      deb_ticks(n);
      btn_startstop = 1'b0;
      btn_clear     = 1'b0;
`ifdef STOPWATCH_LAP_EN
      btn_lap       = 1'b0;
`endif
      wait_cycles(4);
      deb_ticks(5);
      if (l) wait_cycles(1);
   endtask

   task automatic set_vec(input int i, input bit s, input bit c, input int t, input int m,
                          input bit r, input logic [7:0] mn, input logic [7:0] sc,
                          input logic [7:0] ce, input bit o);
      vecs[i].start = s;
      vecs[i].clr   = c;
      vecs[i].ticks = t;
      vecs[i].ms    = m;
      vecs[i].run   = r;
      vecs[i].mn    = mn;
      vecs[i].sc    = sc;
      vecs[i].ce    = ce;
      vecs[i].ovf   = o;
   endtask

   initial begin
      //       idx st cl tk   ms  run  min    sec    centi  ovf
      set_vec(0,  1, 0, 6,  250, 1, 8'h00, 8'h00, 8'h25, 0);  // start, 250 ms
      set_vec(1,  1, 0, 3,    0, 1, 8'h00, 8'h00, 8'h25, 0);  // glitch, ignored
      set_vec(2,  0, 0, 0, 1003, 1, 8'h00, 8'h01, 8'h25, 0);  // centi->sec carry
      set_vec(3,  1, 0, 6,   50, 0, 8'h00, 8'h01, 8'h25, 0);  // pause, no count
      set_vec(4,  1, 0, 6,    6, 1, 8'h00, 8'h01, 8'h25, 0);  // resume, prescaler kept
      set_vec(5,  0, 0, 0,    1, 1, 8'h00, 8'h01, 8'h26, 0);  // prescaler completes
      set_vec(6,  0, 1, 6,    0, 1, 8'h00, 8'h01, 8'h26, 0);  // clear in RUN ignored
      set_vec(7,  1, 1, 6,    0, 0, 8'h00, 8'h01, 8'h26, 0);  // both in RUN -> PAUSE
      set_vec(8,  1, 1, 6,    0, 0, 8'h00, 8'h00, 8'h00, 0);  // both in PAUSE -> IDLE
      set_vec(9,  0, 1, 6,    0, 0, 8'h00, 8'h00, 8'h00, 0);  // clear in IDLE
      set_vec(10, 0, 0, 0,   20, 0, 8'h00, 8'h00, 8'h00, 0);  // no count in IDLE

      // Reset held across several ms edges.
      rst_n = 1'b0;
      wait_cycles(3);
      ms_edges(5);
      check_state("reset", 0, 8'h00, 8'h00, 8'h00, 0);
      rst_n = 1'b1;
      wait_cycles(4);

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].start || vecs[i].clr) press(vecs[i].start, vecs[i].clr, 1'b0, vecs[i].ticks);
         ms_edges(vecs[i].ms);
         check_state($sformatf("v%0d", i), vecs[i].run, vecs[i].mn, vecs[i].sc, vecs[i].ce, vecs[i].ovf);
      end

      // Rollover: preload 59:59.98 with the prescaler at 0, then 20 ms.
      press(1, 0, 0, 6);
      check("roll_start_running", 32'(running), 32'd1);
      force dut.time_d = 24'h595998;
      wait_cycles(1);
      release dut.time_d;
      wait_cycles(1);
      ms_edges(10);
      check_state("roll_pre", 1, 8'h59, 8'h59, 8'h99, 0);
      ms_edges(10);
      check_state("roll_wrap", 0, 8'h00, 8'h00, 8'h00, 1);
      ms_edges(15);
      check_state("roll_paused", 0, 8'h00, 8'h00, 8'h00, 1);
      press(0, 1, 0, 6);
      check_state("roll_clear", 0, 8'h00, 8'h00, 8'h00, 0);
      press(1, 0, 0, 6);
      check("idle_to_run", 32'(running), 32'd1);

      // Reset in the middle of counting.
      ms_edges(35);
      check_state("mid_pre", 1, 8'h00, 8'h00, 8'h03, 0);
      rst_n = 1'b0;
      ms_edges(5);
      check_state("mid_reset", 0, 8'h00, 8'h00, 8'h00, 0);
      rst_n = 1'b1;
      wait_cycles(4);
      ms_edges(20);
      check_state("mid_after", 0, 8'h00, 8'h00, 8'h00, 0);

`ifdef STOPWATCH_LAP_EN
      check("lap_reset", 32'(lap_active), 32'd0);
      press(1, 0, 0, 6);
      ms_edges(1500);
      check_state("lap_pre", 1, 8'h00, 8'h01, 8'h50, 0);
      press(0, 0, 1, 6);
      check("lap_on", 32'(lap_active), 32'd1);
      ms_edges(300);
      check_state("lap_hold", 1, 8'h00, 8'h01, 8'h50, 0);
      press(0, 0, 1, 6);
      check("lap_off", 32'(lap_active), 32'd0);
      check_state("lap_live", 1, 8'h00, 8'h01, 8'h80, 0);
      press(0, 0, 1, 6);
      ms_edges(20);
      check_state("lap_hold2", 1, 8'h00, 8'h01, 8'h80, 0);
      press(1, 0, 0, 6);
      check("lap_pause_clears", 32'(lap_active), 32'd0);
      check_state("lap_paused_live", 0, 8'h00, 8'h01, 8'h82, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
